npc_ctrl: RTL
=============

// Module: npc_ctrl
// PURPOSE
//  Next-PC / fetch-request controller; consumes br from the ID-stage branch comparator (cmp).
//  Holds the PC, issues valid/ready requests to instruction memory, and applies taken
//  branch/jump redirects after the delay slot (MIPS delay-slot semantics, no flush).
//  Sits between the ID-stage resolve logic and the IF-stage instruction memory port.
// PARAMETERS
//  RESET_PC  32'hBFC0_0000  first fetch address after reset
//  CNT_W     16             width of taken-redirect counter
// PORTS
//  clk          in   1      clock; all state on rising edge
//  rst          in   1      synchronous, active-high reset
//  stall_i      in   1      hazard-unit stall: no new fetch request, no redirect capture
//  id_valid     in   1      ID-stage instruction valid
//  id_pc        in   32     PC of ID-stage instruction
//  is_branch    in   1      ID instruction is conditional branch
//  is_j         in   1      ID instruction is j/jal
//  is_jr        in   1      ID instruction is jr/jalr
//  br_i         in   1      taken result from cmp
//  imm16        in   16     branch offset field
//  instr_index  in   26     jump index field
//  jr_target    in   32     forwarded rs value
//  if_ready     in   1      instruction memory accepts request
//  if_req       out  1      fetch request valid
//  if_pc        out  32     fetch address
//  redirect     out  1      1-cycle pulse: redirect applied to PC this cycle
//  addr_err     out  1      1-cycle pulse: jr target with [1:0]!=0 captured
//  taken_cnt    out  CNT_W  count of applied redirects, wraps
// BEHAVIOUR
//  Reset: state=BOOT, pc_q=RESET_PC, if_req=0, if_pc=RESET_PC, pend_v=0, redirect=0,
//   addr_err=0, taken_cnt=0. Reset asserted mid-handshake discards request and pending redirect.
//  FSM: BOOT -> FETCH if !stall_i else HALT (BOOT lasts exactly 1 cycle).
//   FETCH: if_req=1. Accept = if_req&&if_ready. On accept: stall_i ? HALT : FETCH.
//   No accept: stay FETCH; if_req and if_pc held stable even if stall_i rises.
//   HALT: if_req=0; -> FETCH when !stall_i.
//  if_pc = pc_q. On accept: pc_q <= pend_v|cap ? target : pc_q+4 (mod 2^32).
//  Capture cond cap = id_valid && !stall_i && (is_jr | is_j | (is_branch & br_i)).
//   Priority when several set: is_jr > is_j > is_branch. Not-taken branch: no effect.
//  Targets (32-bit, wrap): branch = id_pc+4+{{14{imm16[15]}},imm16,2'b00};
//   j = {(id_pc+4)[31:28],instr_index,2'b00}; jr = jr_target unmodified.
//  Capture with no accept same cycle -> pend_v=1, pend_tgt=target; applied on next accept.
//  Capture and accept same cycle -> target applied directly; pend_v stays 0.
//  Capture while pend_v=1 (branch in delay slot): ignored; pending target kept.
//  pend_v survives HALT/stall; cleared when applied.
//  redirect=1 and taken_cnt+=1 in the cycle target loads into pc_q (registered next edge, pulse).
//  addr_err=1 in cycle after a jr capture with jr_target[1:0]!=0; redirect still proceeds.
//  Latency: capture -> new if_pc visible 1 cycle after the delay-slot accept.
// STRUCTURE
//  Shared package mips_pkg: RESET_PC default, npc_state_t enum {BOOT,FETCH,HALT}.
//  Sub-module npc_target: combinational target mux/adder (imm16, instr_index, jr_target,
//   id_pc, select bits) -> target[31:0], misaligned. Remainder: FSM, pc_q, pend regs, counter.
// TESTING
//  1 Reset release, if_ready=1 always -> BOOT 1 cycle, then if_pc BFC00000,BFC00004,BFC00008.
//  2 id_pc=00400010, is_branch=1, br_i=1, imm16=FFFE, accept same cycle -> next if_pc
//    0040000C, redirect pulse, taken_cnt=1; br_i=0 -> sequential 4-step continues.
//  3 Capture j instr_index=0x0100000 with if_ready=0 for 3 cycles -> if_pc held, pend_v=1;
//    on accept if_pc becomes {id_pc+4[31:28],0x0100000,00}=00400000.
//  4 stall_i=1 while request outstanding -> if_req held until accept, then HALT (if_req=0);
//    pending redirect applied on first accept after stall_i drops.
//  5 jr_target=00400013 -> addr_err pulse, if_pc 00400013; simultaneous is_j ignored (jr wins).
//  6 rst asserted with pend_v=1 and if_ready=0 -> next cycle if_pc=BFC00000, if_req=0,
//    pending target never fetched, taken_cnt=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: reset vector, next-PC FSM states, branch offset helper.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } npc_state_t;

    // Sign-extended word offset of a conditional branch, in bytes.
    function automatic logic [31:0] br_offset(input logic [15:0] imm);
        br_offset = {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/npc_target.sv
// Combinational redirect target: jr beats j beats branch; flags a misaligned jr target.
module npc_target
    import mips_pkg::*;
(
    input  logic [31:0] id_pc,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] jr_target,
    input  logic        sel_jr,
    input  logic        sel_j,
    output logic [31:0] target,
    output logic        misaligned
);

    logic [31:0] pc_plus4;

    assign pc_plus4 = id_pc + 32'd4;

    always_comb begin
        target = pc_plus4 + br_offset(imm16);
        if (sel_jr) begin
            target = jr_target;
        end else if (sel_j) begin
            target = {pc_plus4[31:28], instr_index, 2'b00};
        end
    end

    assign misaligned = sel_jr && (jr_target[1:0] != 2'b00);

endmodule

// File: rtl/npc_ctrl.sv
// Next-PC controller: holds the PC, issues fetch requests, applies taken redirects after the delay slot.
module npc_ctrl
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          CNT_W    = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             id_valid,
    input  logic [31:0]      id_pc,
    input  logic             is_branch,
    input  logic             is_j,
    input  logic             is_jr,
    input  logic             br_i,
    input  logic [15:0]      imm16,
    input  logic [25:0]      instr_index,
    input  logic [31:0]      jr_target,
    input  logic             if_ready,
    output logic             if_req,
    output logic [31:0]      if_pc,
    output logic             redirect,
    output logic             addr_err,
    output logic [CNT_W-1:0] taken_cnt
);

    npc_state_t  state;
    logic [31:0] pc_q;
    logic [31:0] pend_tgt;
    logic        pend_v;
    logic [31:0] tgt;
    logic        misaligned;
    logic        accept;
    logic        cap;
    logic        take;
    logic        apply;

    npc_target u_target (
        .id_pc       (id_pc),
        .imm16       (imm16),
        .instr_index (instr_index),
        .jr_target   (jr_target),
        .sel_jr      (is_jr),
        .sel_j       (is_j),
        .target      (tgt),
        .misaligned  (misaligned)
    );

    assign accept = if_req && if_ready;
    assign cap    = id_valid && !stall_i && (is_jr || is_j || (is_branch && br_i));
    // A branch sitting in the delay slot of a pending redirect is dropped.
    assign take   = cap && !pend_v;
    assign apply  = accept && (pend_v || take);
    assign if_pc  = pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= BOOT;
            pc_q      <= RESET_PC;
            if_req    <= 1'b0;
            pend_v    <= 1'b0;
            pend_tgt  <= '0;
            redirect  <= 1'b0;
            addr_err  <= 1'b0;
            taken_cnt <= '0;
        end else begin
            redirect <= apply;
            addr_err <= take && misaligned;
            if (apply) begin
                taken_cnt <= taken_cnt + CNT_W'(1);
            end

            if (accept) begin
                if (pend_v) begin
                    pc_q <= pend_tgt;
                end else if (take) begin
                    pc_q <= tgt;
                end else begin
                    pc_q <= pc_q + 32'd4;
                end
            end

            if (take && !accept) begin
                pend_v   <= 1'b1;
                pend_tgt <= tgt;
            end else if (accept && pend_v) begin
                pend_v <= 1'b0;
            end

            case (state)
                BOOT: begin
                    state  <= stall_i ? HALT : FETCH;
                    if_req <= !stall_i;
                end
                FETCH: begin
                    // An outstanding request is held until taken, even under stall.
                    if (accept && stall_i) begin
                        state  <= HALT;
                        if_req <= 1'b0;
                    end
                end
                HALT: begin
                    if (!stall_i) begin
                        state  <= FETCH;
                        if_req <= 1'b1;
                    end
                end
                default: begin
                    state  <= BOOT;
                    if_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
